// File: rtl/switch_input_ctrl.sv
// Switch input peripheral: two-flop synchroniser, per-bit counter debounce, sticky
// rise/fall flags and a level interrupt, exposed as a four-register bus window.
module switch_input_ctrl #(
    parameter int unsigned WIDTH           = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 100000,
    parameter int unsigned CNT_WIDTH       = 17
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] switch,
    input  logic             bus_valid,
    input  logic             bus_we,
    input  logic [3:0]       bus_addr,
    input  logic [31:0]      bus_wdata,
    output logic             bus_ready,
    output logic [31:0]      bus_rdata,
    output logic             irq
);

    typedef enum logic [1:0] {
        RegState = 2'd0,
        RegRise  = 2'd1,
        RegFall  = 2'd2,
        RegIrqEn = 2'd3
    } reg_sel_e;

    localparam logic [CNT_WIDTH-1:0] CntLast = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CntOne  = CNT_WIDTH'(1);

    logic [WIDTH-1:0]     sync1_q, sync2_q;
    logic [WIDTH-1:0]     stable_q, stable_d;
    logic [CNT_WIDTH-1:0] cnt_q [WIDTH];
    logic [CNT_WIDTH-1:0] cnt_d [WIDTH];
    logic [WIDTH-1:0]     rise_q, rise_d;
    logic [WIDTH-1:0]     fall_q, fall_d;
    logic [WIDTH-1:0]     irq_en_q, irq_en_d;
    logic                 bus_ready_q, bus_ready_d;
    logic [31:0]          bus_rdata_q, bus_rdata_d;
    logic                 irq_q, irq_d;

    logic                 accept;
    logic                 wr;
    reg_sel_e             reg_sel;
    logic [WIDTH-1:0]     wmask;
    logic [WIDTH-1:0]     rise_set, fall_set;
    logic [31:0]          rd_val;
    logic                 unused_bits;

    // Byte-lane bits of the address and write-data bits above WIDTH carry no meaning.
    assign unused_bits = ^{bus_addr[1:0], bus_wdata};

    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (sync2_q[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CntLast) begin
                stable_d[i] = sync2_q[i];
                cnt_d[i]    = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CntOne;
            end
        end
    end

    always_comb begin
        accept   = bus_valid & ~bus_ready_q;
        wr       = accept & bus_we;
        reg_sel  = reg_sel_e'(bus_addr[3:2]);
        wmask    = bus_wdata[WIDTH-1:0];
        rise_set = ~stable_q & stable_d;
        fall_set = stable_q & ~stable_d;

        rd_val = '0;
        unique case (reg_sel)
            RegState: rd_val = 32'(stable_q);
            RegRise:  rd_val = 32'(rise_q);
            RegFall:  rd_val = 32'(fall_q);
            RegIrqEn: rd_val = 32'(irq_en_q);
        endcase

        // A new edge in the same cycle as a W1C of that bit keeps the flag set.
        rise_d = rise_q;
        fall_d = fall_q;
        irq_en_d = irq_en_q;
        if (wr && reg_sel == RegRise)  rise_d   = rise_q & ~wmask;
        if (wr && reg_sel == RegFall)  fall_d   = fall_q & ~wmask;
        if (wr && reg_sel == RegIrqEn) irq_en_d = wmask;
        rise_d = rise_d | rise_set;
        fall_d = fall_d | fall_set;

        bus_ready_d = accept;
        bus_rdata_d = accept ? rd_val : bus_rdata_q;
        irq_d       = |((rise_q | fall_q) & irq_en_q);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            stable_q    <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
            rise_q      <= '0;
            fall_q      <= '0;
            irq_en_q    <= '0;
            bus_ready_q <= 1'b0;
            bus_rdata_q <= '0;
            irq_q       <= 1'b0;
        end else begin
            sync1_q     <= switch;
            sync2_q     <= sync1_q;
            stable_q    <= stable_d;
            cnt_q       <= cnt_d;
            rise_q      <= rise_d;
            fall_q      <= fall_d;
            irq_en_q    <= irq_en_d;
            bus_ready_q <= bus_ready_d;
            bus_rdata_q <= bus_rdata_d;
            irq_q       <= irq_d;
        end
    end

    assign bus_ready = bus_ready_q;
    assign bus_rdata = bus_rdata_q;
    assign irq       = irq_q;

endmodule

// File: tb/tb_switch_input_ctrl.sv
// Bench for switch_input_ctrl: directed scenarios plus a randomized run checked
// against a window-based reference model of the debounce and register behaviour.
module tb_switch_input_ctrl;

    localparam int W = 4;
    localparam int D = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  switch = '0;
    logic        bus_valid = 1'b0;
    logic        bus_we = 1'b0;
    logic [3:0]  bus_addr = '0;
    logic [31:0] bus_wdata = '0;
    logic        bus_ready;
    logic [31:0] bus_rdata;
    logic        irq;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    switch_input_ctrl #(
        .WIDTH          (W),
        .DEBOUNCE_CYCLES(D),
        .CNT_WIDTH      (3)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .switch   (switch),
        .bus_valid(bus_valid),
        .bus_we   (bus_we),
        .bus_addr (bus_addr),
        .bus_wdata(bus_wdata),
        .bus_ready(bus_ready),
        .bus_rdata(bus_rdata),
        .irq      (irq)
    );

    // Reference model: a bit is accepted once the last D synced samples all disagree
    // with the current stable value.
    logic [3:0]  m_s1, m_s2, m_stable, m_rise, m_fall, m_en;
    logic        m_ready, m_irq;
    logic [31:0] m_rdata;
    logic [3:0]  hist [$];

    always @(posedge clk) begin : model
        logic        acc;
        logic [31:0] sel;
        logic [3:0]  nstab;
        bit          all_diff;
        if (!reset) begin
            m_s1 = '0; m_s2 = '0; m_stable = '0; m_rise = '0; m_fall = '0; m_en = '0;
            m_ready = 1'b0; m_irq = 1'b0; m_rdata = '0;
            hist.delete();
        end else begin
            acc = bus_valid && !m_ready;
            case (bus_addr[3:2])
                2'd0:    sel = {28'b0, m_stable};
                2'd1:    sel = {28'b0, m_rise};
                2'd2:    sel = {28'b0, m_fall};
                default: sel = {28'b0, m_en};
            endcase
            m_irq = |((m_rise | m_fall) & m_en);
            hist.push_back(m_s2);
            if (hist.size() > D) void'(hist.pop_front());
            nstab = m_stable;
            if (hist.size() == D) begin
                for (int i = 0; i < W; i++) begin
                    all_diff = 1'b1;
                    for (int k = 0; k < D; k++) if (hist[k][i] == m_stable[i]) all_diff = 1'b0;
                    if (all_diff) nstab[i] = ~m_stable[i];
                end
            end
            if (acc && bus_we) begin
                case (bus_addr[3:2])
                    2'd1:    m_rise = m_rise & ~bus_wdata[3:0];
                    2'd2:    m_fall = m_fall & ~bus_wdata[3:0];
                    2'd3:    m_en = bus_wdata[3:0];
                    default: ;
                endcase
            end
            m_rise   = m_rise | (~m_stable & nstab);
            m_fall   = m_fall | (m_stable & ~nstab);
            m_stable = nstab;
            if (acc) m_rdata = sel;
            m_ready = acc;
            m_s2 = m_s1;
            m_s1 = switch;
        end
    end

    // Called at a negedge; returns at the negedge after the response (rdata = x on timeout).
    task automatic bus_xfer(input logic we, input logic [3:0] addr, input logic [31:0] wdata,
                            output logic [31:0] rdata);
        bit got;
        got = 1'b0;
        rdata = 'x;
        bus_valid = 1'b1; bus_we = we; bus_addr = addr; bus_wdata = wdata;
        for (int i = 0; i < 8 && !got; i++) begin
            @(posedge clk); #1;
            if (bus_ready) begin
                got = 1'b1;
                rdata = bus_rdata;
            end
        end
        @(negedge clk);
        bus_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0; bus_valid = 1'b0; switch = '0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        do_reset();
        n_vec++;
        if ({bus_ready, bus_rdata, irq} !== 34'b0) begin
            n_err++;
            $display("FAIL reset_outputs: got %b/%h/%b expected 0/0/0", bus_ready, bus_rdata, irq);
        end
        bus_xfer(1'b0, 4'h0, 32'h0, rd);
        n_vec++;
        if (rd !== 32'h0) begin n_err++; $display("FAIL reset_state: got %h expected 0", rd); end
    endtask

    task automatic test_debounce_rise();
        logic [31:0] rd;
        do_reset();
        repeat (6) @(negedge clk);
        switch = 4'b0001;
        repeat (5) @(negedge clk);
        bus_xfer(1'b0, 4'h0, 32'h0, rd);
        n_vec++;
        if (rd !== 32'h0) begin n_err++; $display("FAIL rise_state_early: got %h expected 0", rd); end
        bus_xfer(1'b0, 4'h0, 32'h0, rd);
        n_vec++;
        if (rd !== 32'h1) begin n_err++; $display("FAIL rise_state: got %h expected 1", rd); end
        bus_xfer(1'b0, 4'h4, 32'h0, rd);
        n_vec++;
        if (rd !== 32'h1) begin n_err++; $display("FAIL rise_flag: got %h expected 1", rd); end
        bus_xfer(1'b0, 4'h8, 32'h0, rd);
        n_vec++;
        if (rd !== 32'h0) begin n_err++; $display("FAIL rise_fall_flag: got %h expected 0", rd); end
    endtask

    task automatic test_glitch();
        logic [31:0] rd;
        do_reset();
        repeat (6) @(negedge clk);
        switch = 4'b0100; repeat (3) @(negedge clk);
        switch = 4'b0000; repeat (1) @(negedge clk);
        switch = 4'b0100; repeat (3) @(negedge clk);
        switch = 4'b0000; repeat (8) @(negedge clk);
        bus_xfer(1'b0, 4'h0, 32'h0, rd);
        n_vec++;
        if (rd !== 32'h0) begin n_err++; $display("FAIL glitch_state: got %h expected 0", rd); end
        bus_xfer(1'b0, 4'h4, 32'h0, rd);
        n_vec++;
        if (rd !== 32'h0) begin n_err++; $display("FAIL glitch_rise: got %h expected 0", rd); end
        // A counter left non-zero by the glitches would shorten this full-latency change.
        switch = 4'b0100;
        repeat (5) @(negedge clk);
        bus_xfer(1'b0, 4'h0, 32'h0, rd);
        n_vec++;
        if (rd !== 32'h0) begin n_err++; $display("FAIL glitch_cnt_restart: got %h expected 0", rd); end
        bus_xfer(1'b0, 4'h0, 32'h0, rd);
        n_vec++;
        if (rd !== 32'h4) begin n_err++; $display("FAIL glitch_after: got %h expected 4", rd); end
    endtask

    task automatic test_irq();
        logic [31:0] rd;
        do_reset();
        switch = 4'b0010;
        repeat (10) @(negedge clk);
        bus_xfer(1'b1, 4'h4, 32'hF, rd);
        bus_xfer(1'b1, 4'hC, 32'hF, rd);
        repeat (2) @(negedge clk);
        n_vec++;
        if (irq !== 1'b0) begin n_err++; $display("FAIL irq_idle: got %b expected 0", irq); end
        bus_xfer(1'b0, 4'hC, 32'h0, rd);
        n_vec++;
        if (rd !== 32'hF) begin n_err++; $display("FAIL irq_en_read: got %h expected f", rd); end
        switch = 4'b0000;
        repeat (6) @(posedge clk);
        #1;
        n_vec++;
        if (irq !== 1'b0) begin n_err++; $display("FAIL irq_early: got %b expected 0", irq); end
        @(posedge clk); #1;
        n_vec++;
        if (irq !== 1'b1) begin n_err++; $display("FAIL irq_set: got %b expected 1", irq); end
        @(negedge clk);
        bus_xfer(1'b0, 4'h8, 32'h0, rd);
        n_vec++;
        if (rd !== 32'h2) begin n_err++; $display("FAIL irq_fall_flag: got %h expected 2", rd); end
        bus_xfer(1'b1, 4'h8, 32'h2, rd);
        n_vec++;
        if (irq !== 1'b1) begin n_err++; $display("FAIL irq_hold: got %b expected 1", irq); end
        @(posedge clk); #1;
        n_vec++;
        if (irq !== 1'b0) begin n_err++; $display("FAIL irq_clear: got %b expected 0", irq); end
        @(negedge clk);
    endtask

    task automatic test_w1c_collision();
        logic [31:0] rd;
        do_reset();
        repeat (6) @(negedge clk);
        switch = 4'b1000;
        repeat (5) @(negedge clk);
        bus_xfer(1'b1, 4'h4, 32'h8, rd);
        bus_xfer(1'b0, 4'h4, 32'h0, rd);
        n_vec++;
        if (rd !== 32'h8) begin n_err++; $display("FAIL w1c_set_wins: got %h expected 8", rd); end
        bus_xfer(1'b1, 4'h4, 32'h8, rd);
        bus_xfer(1'b0, 4'h4, 32'h0, rd);
        n_vec++;
        if (rd !== 32'h0) begin n_err++; $display("FAIL w1c_clear: got %h expected 0", rd); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd;
        logic [31:0] exp_rd [4];
        int idx;
        bus_xfer(1'b1, 4'hC, 32'h5, rd);
        switch = 4'b0000; repeat (10) @(negedge clk);
        switch = 4'b0011; repeat (10) @(negedge clk);
        exp_rd = '{32'h3, 32'h3, 32'h8, 32'h5};
        idx = 0;
        bus_valid = 1'b1; bus_we = 1'b0; bus_addr = 4'h0;
        for (int cyc = 0; cyc < 9; cyc++) begin
            @(posedge clk); #1;
            n_vec++;
            if (bus_ready !== ((cyc % 2 == 0) && cyc < 8)) begin
                n_err++;
                $display("FAIL b2b_ready cyc %0d: got %b expected %b", cyc, bus_ready, cyc % 2 == 0);
            end
            if (bus_ready === 1'b1 && idx < 4) begin
                n_vec++;
                if (bus_rdata !== exp_rd[idx]) begin
                    n_err++;
                    $display("FAIL b2b_rdata %0d: got %h expected %h", idx, bus_rdata, exp_rd[idx]);
                end
                idx++;
            end
            @(negedge clk);
            if (bus_ready) begin
                if (idx < 4) bus_addr = 4'(idx * 4);
                else bus_valid = 1'b0;
            end
        end
        bus_valid = 1'b0;
        n_vec++;
        if (idx !== 4) begin n_err++; $display("FAIL b2b_count: got %0d expected 4", idx); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd;
        switch = 4'hF;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            n_vec++;
            if ({bus_ready, bus_rdata, irq} !== 34'b0) begin
                n_err++;
                $display("FAIL mid_reset_outputs: got %b/%h/%b expected 0/0/0",
                         bus_ready, bus_rdata, irq);
            end
        end
        @(negedge clk);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        bus_xfer(1'b0, 4'h0, 32'h0, rd);
        n_vec++;
        if (rd !== 32'h0) begin n_err++; $display("FAIL mid_state_early: got %h expected 0", rd); end
        bus_xfer(1'b0, 4'h4, 32'h0, rd);
        n_vec++;
        if (rd !== 32'hF) begin n_err++; $display("FAIL mid_rise: got %h expected f", rd); end
        bus_xfer(1'b0, 4'h0, 32'h0, rd);
        n_vec++;
        if (rd !== 32'hF) begin n_err++; $display("FAIL mid_state: got %h expected f", rd); end
        bus_xfer(1'b0, 4'hC, 32'h0, rd);
        n_vec++;
        if (rd !== 32'h0) begin n_err++; $display("FAIL mid_irq_en: got %h expected 0", rd); end
    endtask

    task automatic test_random();
        do_reset();
        for (int cyc = 0; cyc < 1500; cyc++) begin
            for (int b = 0; b < W; b++) if ($urandom_range(0, 5) == 0) switch[b] = ~switch[b];
            reset = ($urandom_range(0, 299) != 0);
            if (bus_valid && bus_ready) begin
                if ($urandom_range(0, 1) == 0) bus_valid = 1'b0;
                else begin
                    bus_we = 1'($urandom); bus_addr = 4'($urandom); bus_wdata = $urandom;
                end
            end else if (!bus_valid && $urandom_range(0, 2) == 0) begin
                bus_valid = 1'b1;
                bus_we = 1'($urandom); bus_addr = 4'($urandom); bus_wdata = $urandom;
            end
            @(posedge clk); #1;
            n_vec++;
            if ({bus_ready, bus_rdata, irq} !== {m_ready, m_rdata, m_irq}) begin
                n_err++;
                $display("FAIL random cyc %0d: got %b/%h/%b expected %b/%h/%b", cyc,
                         bus_ready, bus_rdata, irq, m_ready, m_rdata, m_irq);
            end
            @(negedge clk);
        end
        bus_valid = 1'b0;
        reset = 1'b1;
    endtask

    initial begin
        test_reset();
        test_debounce_rise();
        test_glitch();
        test_irq();
        test_w1c_collision();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
